// File: rtl/video_timing_gen_if.sv
// Setup and pixel-stream bundle of the video timing generator.
// master = timing generator side, slave = controller / pixel sink side.
interface video_timing_gen_if #(
  parameter int widthAddr  = 12,
  parameter int heightAddr = 12
);
  logic                  setup__ENA;
  logic                  setup__RDY;
  logic [widthAddr-1:0]  setup_hTotal;
  logic [widthAddr-1:0]  setup_hActive;
  logic [widthAddr-1:0]  setup_hSyncStart;
  logic [widthAddr-1:0]  setup_hSyncWidth;
  logic [heightAddr-1:0] setup_vTotal;
  logic [heightAddr-1:0] setup_vActive;
  logic [heightAddr-1:0] setup_vSyncStart;
  logic [heightAddr-1:0] setup_vSyncWidth;

  logic                  setXY__ENA;
  logic                  setXY__RDY;
  logic [widthAddr-1:0]  setXY_x;
  logic [heightAddr-1:0] setXY_y;
  logic                  setXY_dataEnable;

  modport master (
    input  setup__ENA,
    input  setup_hTotal,
    input  setup_hActive,
    input  setup_hSyncStart,
    input  setup_hSyncWidth,
    input  setup_vTotal,
    input  setup_vActive,
    input  setup_vSyncStart,
    input  setup_vSyncWidth,
    output setup__RDY,
    output setXY__ENA,
    output setXY_x,
    output setXY_y,
    output setXY_dataEnable,
    input  setXY__RDY
  );

  modport slave (
    output setup__ENA,
    output setup_hTotal,
    output setup_hActive,
    output setup_hSyncStart,
    output setup_hSyncWidth,
    output setup_vTotal,
    output setup_vActive,
    output setup_vSyncStart,
    output setup_vSyncWidth,
    input  setup__RDY,
    input  setXY__ENA,
    input  setXY_x,
    input  setXY_y,
    input  setXY_dataEnable,
    output setXY__RDY
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/active decode,
// shadowed reconfiguration applied at the frame boundary.
module video_timing_gen #(
  parameter int widthAddr  = 12,
  parameter int heightAddr = 12,
  parameter bit hsPol      = 1'b1,
  parameter bit vsPol      = 1'b1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  video_timing_gen_if.master       bus,
  input  logic                     stop__ENA,
  output logic                     stop__RDY,
  output logic                     hSync,
  output logic                     vSync,
  output logic                     dataEnable,
  output logic                     frameStart,
  output logic [15:0]              frameCount,
  output logic                     underrun,
  output logic                     configError
);

  localparam int W = widthAddr;
  localparam int H = heightAddr;

  typedef struct packed {
    logic [W-1:0] h_total;
    logic [W-1:0] h_active;
    logic [W-1:0] hs_start;
    logic [W-1:0] hs_width;
    logic [H-1:0] v_total;
    logic [H-1:0] v_active;
    logic [H-1:0] vs_start;
    logic [H-1:0] vs_width;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  state_t       state;
  cfg_t         act;
  cfg_t         shadow;
  cfg_t         req;
  logic [W-1:0] hc;
  logic [H-1:0] vc;

  logic [W:0]   req_hs_end;
  logic [H:0]   req_vs_end;
  logic         cfg_ok;

  logic [W:0]   hs_end;
  logic [H:0]   vs_end;
  logic         hs_hit;
  logic         vs_hit;
  logic         active_px;
  logic         h_last;
  logic         v_last;
  logic         origin;

  always_comb begin
    req          = '0;
    req.h_total  = bus.setup_hTotal;
    req.h_active = bus.setup_hActive;
    req.hs_start = bus.setup_hSyncStart;
    req.hs_width = bus.setup_hSyncWidth;
    req.v_total  = bus.setup_vTotal;
    req.v_active = bus.setup_vActive;
    req.vs_start = bus.setup_vSyncStart;
    req.vs_width = bus.setup_vSyncWidth;
  end

  // Sync end positions need one extra bit so start+width cannot wrap.
  assign req_hs_end = {1'b0, req.hs_start}
                    + {1'b0, req.hs_width};
  assign req_vs_end = {1'b0, req.vs_start}
                    + {1'b0, req.vs_width};

  assign cfg_ok = (req.h_total >= W'(2))
               && (req.v_total >= H'(2))
               && (req.h_active >= W'(1))
               && (req.h_active <= req.h_total)
               && (req.v_active >= H'(1))
               && (req.v_active <= req.v_total)
               && (req_hs_end <= {1'b0, req.h_total})
               && (req_vs_end <= {1'b0, req.v_total});

  assign hs_end = {1'b0, act.hs_start}
                + {1'b0, act.hs_width};
  assign vs_end = {1'b0, act.vs_start}
                + {1'b0, act.vs_width};

  assign hs_hit = (hc >= act.hs_start)
               && ({1'b0, hc} < hs_end);
  assign vs_hit = (vc >= act.vs_start)
               && ({1'b0, vc} < vs_end);

  assign active_px = (hc < act.h_active)
                  && (vc < act.v_active);

  assign h_last = (hc == act.h_total - W'(1));
  assign v_last = (vc == act.v_total - H'(1));
  assign origin = (hc == '0) && (vc == '0);

  assign stop__RDY            = 1'b1;
  assign bus.setup__RDY       = (state != PEND);
  assign bus.setXY__ENA       = (state != IDLE);
  assign bus.setXY_x          = hc;
  assign bus.setXY_y          = vc;
  assign bus.setXY_dataEnable = active_px;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      act         <= '0;
      shadow      <= '0;
      hc          <= '0;
      vc          <= '0;
      frameCount  <= '0;
      underrun    <= 1'b0;
      configError <= 1'b0;
      dataEnable  <= 1'b0;
      frameStart  <= 1'b0;
      hSync       <= ~hsPol;
      vSync       <= ~vsPol;
    end else if (stop__ENA) begin
      state      <= IDLE;
      shadow     <= '0;
      hc         <= '0;
      vc         <= '0;
      dataEnable <= 1'b0;
      frameStart <= 1'b0;
      hSync      <= ~hsPol;
      vSync      <= ~vsPol;
    end else begin
      case (state)
        IDLE: begin
          if (bus.setup__ENA) begin
            if (cfg_ok) begin
              act   <= req;
              hc    <= '0;
              vc    <= '0;
              state <= RUN;
            end else begin
              configError <= 1'b1;
            end
          end
        end
        RUN, PEND: begin
          if (state == RUN && bus.setup__ENA) begin
            if (cfg_ok) begin
              shadow <= req;
              state  <= PEND;
            end else begin
              configError <= 1'b1;
            end
          end
          if (bus.setXY__RDY) begin
            dataEnable <= active_px;
            hSync      <= hs_hit ? hsPol : ~hsPol;
            vSync      <= vs_hit ? vsPol : ~vsPol;
            frameStart <= origin;
            if (origin) begin
              frameCount <= frameCount + 16'd1;
            end
            unique case (1'b1)
              !h_last: begin
                hc <= hc + W'(1);
              end
              h_last && !v_last: begin
                hc <= '0;
                vc <= vc + H'(1);
              end
              default: begin
                hc <= '0;
                vc <= '0;
                // Frame boundary: the waiting timing takes over.
                if (state == PEND) begin
                  act   <= shadow;
                  state <= RUN;
                end
              end
            endcase
          end else begin
            underrun   <= 1'b1;
            frameStart <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: raster-position model checked every cycle against two DUTs
// (active-high and active-low syncs) plus directed frame measurements.
module tb_video_timing_gen;

  localparam int W = 12;
  localparam int H = 12;

  logic        clk;
  logic        nrst;
  logic        stop_ena;
  logic        rdy;
  logic        setup_ena;
  logic [11:0] req [8];

  logic [11:0] CA [8] = '{12'd10, 12'd6, 12'd7, 12'd2,
                          12'd5,  12'd3, 12'd3, 12'd1};
  logic [11:0] CB [8] = '{12'd8,  12'd6, 12'd7, 12'd1,
                          12'd5,  12'd3, 12'd3, 12'd1};
  logic [11:0] CC [8] = '{12'd10, 12'd11, 12'd7, 12'd2,
                          12'd5,  12'd3,  12'd3, 12'd1};

  video_timing_gen_if #(.widthAddr(W), .heightAddr(H)) b1 ();
  video_timing_gen_if #(.widthAddr(W), .heightAddr(H)) b2 ();

  assign b1.setup__ENA       = setup_ena;
  assign b1.setup_hTotal     = req[0];
  assign b1.setup_hActive    = req[1];
  assign b1.setup_hSyncStart = req[2];
  assign b1.setup_hSyncWidth = req[3];
  assign b1.setup_vTotal     = req[4];
  assign b1.setup_vActive    = req[5];
  assign b1.setup_vSyncStart = req[6];
  assign b1.setup_vSyncWidth = req[7];
  assign b1.setXY__RDY       = rdy;

  assign b2.setup__ENA       = setup_ena;
  assign b2.setup_hTotal     = req[0];
  assign b2.setup_hActive    = req[1];
  assign b2.setup_hSyncStart = req[2];
  assign b2.setup_hSyncWidth = req[3];
  assign b2.setup_vTotal     = req[4];
  assign b2.setup_vActive    = req[5];
  assign b2.setup_vSyncStart = req[6];
  assign b2.setup_vSyncWidth = req[7];
  assign b2.setXY__RDY       = rdy;

  logic        sr1, hs1, vs1, de1, fs1, ur1, ce1;
  logic [15:0] fc1;
  logic        sr2, hs2, vs2, de2, fs2, ur2, ce2;
  logic [15:0] fc2;

  video_timing_gen #(
    .widthAddr(W), .heightAddr(H), .hsPol(1'b1), .vsPol(1'b1)
  ) dut1 (
    .CLK(clk), .nRST(nrst), .bus(b1),
    .stop__ENA(stop_ena), .stop__RDY(sr1),
    .hSync(hs1), .vSync(vs1), .dataEnable(de1),
    .frameStart(fs1), .frameCount(fc1),
    .underrun(ur1), .configError(ce1)
  );

  video_timing_gen #(
    .widthAddr(W), .heightAddr(H), .hsPol(1'b0), .vsPol(1'b0)
  ) dut2 (
    .CLK(clk), .nRST(nrst), .bus(b2),
    .stop__ENA(stop_ena), .stop__RDY(sr2),
    .hSync(hs2), .vSync(vs2), .dataEnable(de2),
    .frameStart(fs2), .frameCount(fc2),
    .underrun(ur2), .configError(ce2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a frame is a linear pixel index, x/y derived by div/mod.
  int  mode;
  int  c [8];
  int  s [8];
  int  r [8];
  int  pos, fc, old, ex, ey;
  bit  mhs, mvs, mde, mfs, mur, mce, xde;
  bit  started = 0;

  function automatic bit cfg_ok(input int v [8]);
    return v[0] >= 2 && v[4] >= 2
        && v[1] >= 1 && v[1] <= v[0]
        && v[5] >= 1 && v[5] <= v[4]
        && v[2] + v[3] <= v[0]
        && v[6] + v[7] <= v[4];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (mode == 0) begin
          ex = 0;
          ey = 0;
        end else begin
          ex = pos % c[0];
          ey = pos / c[0];
        end
        xde = (ex < c[1]) && (ey < c[5]);
        chk("xy_ena", b1.setXY__ENA, mode != 0);
        chk("xy_x", b1.setXY_x, ex);
        chk("xy_y", b1.setXY_y, ey);
        chk("xy_de", b1.setXY_dataEnable, xde);
        chk("setup_rdy", b1.setup__RDY, mode != 2);
        chk("stop_rdy", sr1, 1);
        chk("hsync", hs1, mhs);
        chk("vsync", vs1, mvs);
        chk("de", de1, mde);
        chk("fs", fs1, mfs);
        chk("fc", fc1, fc);
        chk("underrun", ur1, mur);
        chk("cfg_err", ce1, mce);
        chk("hsync_n", hs2, !mhs);
        chk("vsync_n", vs2, !mvs);
        chk("de_n", de2, mde);
        chk("x_n", b2.setXY_x, ex);
      end
      foreach (r[i]) r[i] = int'(req[i]);
      if (!nrst) begin
        mode = 0;
        foreach (c[i]) c[i] = 0;
        foreach (s[i]) s[i] = 0;
        pos = 0; fc = 0;
        mhs = 0; mvs = 0; mde = 0; mfs = 0;
        mur = 0; mce = 0;
        started = 1;
      end else if (started) begin
        if (stop_ena) begin
          mode = 0; pos = 0;
          mhs = 0; mvs = 0; mde = 0; mfs = 0;
        end else if (mode == 0) begin
          if (setup_ena) begin
            if (cfg_ok(r)) begin
              c = r; pos = 0; mode = 1;
            end else mce = 1;
          end
        end else begin
          old = mode;
          if (old == 1 && setup_ena) begin
            if (cfg_ok(r)) begin
              s = r; mode = 2;
            end else mce = 1;
          end
          if (rdy) begin
            ex  = pos % c[0];
            ey  = pos / c[0];
            mhs = ex >= c[2] && ex < c[2] + c[3];
            mvs = ey >= c[6] && ey < c[6] + c[7];
            mde = ex < c[1] && ey < c[5];
            mfs = (pos == 0);
            if (pos == 0) fc = (fc + 1) % 65536;
            pos++;
            if (pos == c[0] * c[4]) begin
              pos = 0;
              if (old == 2) begin
                c = s; mode = 1;
              end
            end
          end else begin
            mur = 1; mfs = 0;
          end
        end
      end
    end
  end

  int cyc = 0;
  int lastfs = 0;
  int period = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (fs1 === 1'b1) begin
        period = cyc - lastfs;
        lastfs = cyc;
      end
    end
  end

  task automatic wait_fs(output int p);
    p = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fs1 === 1'b1) begin
        #1;
        p = period;
        return;
      end
    end
    total++; bad++;
    $display("FAIL wait_fs timeout t=%0t", $time);
  endtask

  task automatic wait_x(input int v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b1.setXY_x == 12'(v)) return;
    end
    total++; bad++;
    $display("FAIL wait_x timeout want=%0d", v);
  endtask

  task automatic drive_setup(input logic [11:0] v [8]);
    @(posedge clk); #2;
    req = v;
    setup_ena = 1'b1;
    @(posedge clk); #2;
    setup_ena = 1'b0;
  endtask

  task automatic count_frame(output int nde, output int nhs,
                             output int nvs);
    nde = 0; nhs = 0; nvs = 0;
    for (int i = 0; i < 50; i++) begin
      if (i != 0) @(negedge clk);
      nde += int'(de1);
      nhs += int'(hs1);
      nvs += int'(vs1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int p, nde, nhs, nvs;
  logic [15:0] fcs;

  initial begin
    nrst = 1'b0; stop_ena = 1'b0; rdy = 1'b1;
    setup_ena = 1'b0;
    foreach (req[i]) req[i] = '0;
    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("lit_rst_ena", b1.setXY__ENA, 0);
    chk("lit_rst_rdy", b1.setup__RDY, 1);
    chk("lit_rst_hs_n", hs2, 1);

    drive_setup(CA);
    wait_fs(p);
    wait_fs(p);
    chk("lit_period_a", p, 50);
    count_frame(nde, nhs, nvs);
    chk("lit_de_cnt", nde, 18);
    chk("lit_hs_cnt", nhs, 10);
    chk("lit_vs_cnt", nvs, 10);
    wait_fs(p);
    chk("lit_period_a2", p, 50);

    wait_x(3);
    @(posedge clk); #2 rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lit_stall_x", b1.setXY_x, 4);
    @(posedge clk);
    @(posedge clk); #2 rdy = 1'b1;
    wait_fs(p);
    chk("lit_period_stall", p, 53);
    chk("lit_underrun", ur1, 1);

    drive_setup(CB);
    @(negedge clk);
    chk("lit_pend_rdy", b1.setup__RDY, 0);
    wait_fs(p);
    chk("lit_period_old", p, 50);
    chk("lit_rdy_back", b1.setup__RDY, 1);
    wait_fs(p);
    chk("lit_period_b", p, 40);

    drive_setup(CC);
    @(negedge clk);
    chk("lit_cfg_err", ce1, 1);
    chk("lit_cfg_rdy", b1.setup__RDY, 1);
    wait_fs(p);
    chk("lit_period_keep", p, 40);

    wait_x(2);
    fcs = fc1;
    @(posedge clk); #2;
    req = CA; stop_ena = 1'b1; setup_ena = 1'b1;
    @(posedge clk); #2;
    stop_ena = 1'b0; setup_ena = 1'b0;
    @(negedge clk);
    chk("lit_stop_ena", b1.setXY__ENA, 0);
    chk("lit_stop_hs", hs1, 0);
    chk("lit_stop_vs_n", vs2, 1);
    chk("lit_stop_fc", fc1, fcs);
    drive_setup(CA);
    @(negedge clk);
    chk("lit_restart_ena", b1.setXY__ENA, 1);
    chk("lit_restart_x", b1.setXY_x, 0);
    chk("lit_restart_y", b1.setXY_y, 0);

    repeat (23) @(posedge clk);
    drive_setup(CB);
    @(posedge clk); #2;
    rdy = 1'b0; nrst = 1'b0;
    @(posedge clk); #2;
    nrst = 1'b1; rdy = 1'b1;
    @(negedge clk);
    chk("lit_mrst_fc", fc1, 0);
    chk("lit_mrst_ur", ur1, 0);
    chk("lit_mrst_ce", ce1, 0);
    chk("lit_mrst_hs", hs1, 0);
    chk("lit_mrst_hs_n", hs2, 1);
    chk("lit_mrst_vs_n", vs2, 1);
    chk("lit_mrst_ena", b1.setXY__ENA, 0);
    chk("lit_mrst_rdy", b1.setup__RDY, 1);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter widthAddr, default 12, giving the width of the horizontal counter and fields.
REQ-002 The block SHALL have parameter heightAddr, default 12, giving the width of the vertical counter and fields.
REQ-003 The block SHALL have parameter hsPol, default 1, giving the hSync active level.
REQ-004 The block SHALL have parameter vsPol, default 1, giving the vSync active level.
REQ-005 The block SHALL have one clock and a synchronous active-low reset: CLK in 1 (clock); nRST in 1 (reset).
REQ-006 The block SHALL have the following setup ports:
- setup__ENA in 1: configuration request.
- setup$hTotal, setup$hActive, setup$hSyncStart, setup$hSyncWidth in widthAddr each.
- setup$vTotal, setup$vActive, setup$vSyncStart, setup$vSyncWidth in heightAddr each.
- setup__RDY out 1.
REQ-007 The block SHALL have stop__ENA in 1 (return to idle) and stop__RDY out 1 (always 1).
REQ-008 The block SHALL have the following pixel ports:
- setXY__ENA out 1.
- setXY$x out widthAddr.
- setXY$y out heightAddr.
- setXY$dataEnable out 1.
- setXY__RDY in 1 (downstream ready).
REQ-009 The block SHALL have the following status outputs:
- hSync, vSync, dataEnable out 1 each.
- frameStart out 1.
- frameCount out 16.
- underrun out 1 (sticky).
- configError out 1 (sticky).

Function
REQ-010 The block SHALL implement states IDLE, RUN and PEND (RUN with a shadow configuration waiting).
REQ-011 A setup is valid only if all of these hold: hTotal>=2, vTotal>=2, 1<=hActive<=hTotal, 1<=vActive<=vTotal, hSyncStart+hSyncWidth<=hTotal, vSyncStart+vSyncWidth<=vTotal. Sums SHALL be computed one bit wider.
REQ-012 An invalid setup SHALL be consumed without changing state or configuration, and SHALL set configError.
REQ-013 setup__RDY SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-014 A valid setup in IDLE SHALL load the active configuration, clear hc and vc to 0, and enter RUN on the next cycle.
REQ-015 A valid setup in RUN SHALL load the shadow registers and enter PEND.
REQ-016 In RUN or PEND, the counters SHALL advance only in cycles with setXY__RDY=1. hc increments; at hc==hTotal-1 it wraps to 0 and vc increments; at vc==vTotal-1 with hc wrapping, vc wraps to 0.
REQ-017 At the end-of-frame wrap in PEND, the shadow configuration SHALL become active and the state SHALL return to RUN. The new frame starts at hc=vc=0 using the new timing.
REQ-018 setXY__ENA SHALL equal (state!=IDLE) combinationally. setXY$x=hc, setXY$y=vc, and setXY$dataEnable=(hc<hActive)&&(vc<vActive).
REQ-019 A pixel SHALL be transferred when setXY__ENA&&setXY__RDY.
REQ-020 If setXY__RDY=0 in RUN or PEND, the counters SHALL hold and underrun SHALL be set. underrun SHALL clear only on reset.
REQ-021 dataEnable, hSync and vSync SHALL be registered copies of the current-cycle counter decode, giving 1 cycle latency:
- hSync = hsPol when hSyncStart<=hc<hSyncStart+hSyncWidth, else ~hsPol.
- vSync = vsPol when vSyncStart<=vc<vSyncStart+vSyncWidth, else ~vsPol.
- dataEnable follows the same active-region decode as setXY$dataEnable.
REQ-022 A sync width of 0 SHALL hold that sync at its inactive level.
REQ-023 These registered outputs SHALL update only on advancing cycles.
REQ-024 frameStart SHALL pulse high for one cycle, registered, the cycle after a transfer at hc=0, vc=0.
REQ-025 frameCount SHALL increment by 1 on each such transfer, wrapping 0xFFFF to 0.
REQ-026 stop__ENA SHALL move any state to IDLE on the next cycle. It SHALL discard the shadow configuration, zero hc and vc, drive dataEnable=0 and frameStart=0, and drive the syncs to their inactive levels. frameCount SHALL be retained.
REQ-027 When stop__ENA and setup__ENA occur in the same cycle, stop SHALL win and the setup SHALL be discarded.
REQ-028 A setup in IDLE after a stop SHALL restart at hc=vc=0.

Reset
REQ-029 When nRST=0 at a CLK edge, the block SHALL enter IDLE.
REQ-030 Reset SHALL clear hc, vc, the configuration, the shadow registers, frameCount, underrun, configError, dataEnable and frameStart to 0.
REQ-031 Reset SHALL set hSync=~hsPol and vSync=~vsPol.
REQ-032 After reset, setXY__ENA=0 and setup__RDY=1.
REQ-033 Reset asserted mid-frame SHALL take effect at the next edge regardless of setXY__RDY or pending setup.

Verification
REQ-034 Setup hTotal=10, hActive=6, hSyncStart=7, hSyncWidth=2, vTotal=5, vActive=3, vSyncStart=3, vSyncWidth=1, with RDY=1 -> required response:
- dataEnable is high 6 of every 10 cycles on lines 0-2.
- hSync is high 2 cycles per line, one cycle after hc=7,8.
- vSync is high for line 3.
- frameStart occurs every 50 cycles.
- frameCount increments.
REQ-035 RDY held 0 for 3 cycles at hc=4 -> hc stays 4 for those cycles, outputs stay frozen, underrun=1 sticky, and the frame length becomes 53 cycles.
REQ-036 Second valid setup with hTotal=8 mid-frame -> required response:
- setup__RDY=0 until the frame wraps.
- The first frame finishes with hTotal=10.
- The next line is 8 cycles long.
- setup__RDY returns to 1.
REQ-037 Setup with hActive=11, hTotal=10 -> configError=1 and state, timing and frameCount are unchanged.
REQ-038 stop__ENA and setup__ENA in the same cycle at hc=3 -> required response:
- IDLE next cycle.
- setXY__ENA=0 and syncs inactive.
- frameCount kept.
- A following setup restarts at x=0, y=0.
REQ-039 With hsPol=0 and vsPol=0 -> syncs idle high and pulse low at the same positions as in REQ-034; nRST=0 mid-frame -> all reset values in REQ-030 to REQ-032 on the next edge.
